// File: rtl/lag_measure.sv
// lag_measure: receive side of the display lag test. Synchronises and
// debounces the photo-sensor, times flash_start -> light in clock cycles,
// and keeps last / min / max / 16-sample block average of valid results.
module lag_measure #(
  parameter int                     SYNC_STAGES = 2,
  parameter int                     FILTER_LEN  = 16,
  parameter int                     COUNT_WIDTH = 24,
  parameter logic [COUNT_WIDTH-1:0] TIMEOUT     = COUNT_WIDTH'(10_000_000)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   sensor,
  input  logic                   flash_start,
  input  logic                   enable,
  input  logic                   clear_stats,
  output logic                   sensor_level,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] lag_cycles,
  output logic                   lag_valid,
  output logic                   lag_timeout,
  output logic [COUNT_WIDTH-1:0] lag_min,
  output logic [COUNT_WIDTH-1:0] lag_max,
  output logic [COUNT_WIDTH-1:0] lag_avg,
  output logic                   avg_valid
);

  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int AW = COUNT_WIDTH + 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic [FW-1:0]          filt_cnt_q;
  logic                   level_q;

  state_t                 state_q;
  logic [COUNT_WIDTH-1:0] count_q;
  logic [COUNT_WIDTH-1:0] lag_cycles_q;
  logic                   lag_valid_q;
  logic                   lag_timeout_q;

  logic [COUNT_WIDTH-1:0] min_q;
  logic [COUNT_WIDTH-1:0] max_q;
  logic [AW-1:0]          acc_q;
  logic [3:0]             nsamp_q;
  logic [COUNT_WIDTH-1:0] avg_q;
  logic                   avg_valid_q;

  logic                   hit_d;
  logic                   expire_d;
  logic [AW-1:0]          sum_d;

  assign sync_out = sync_q[SYNC_STAGES-1];

  // Shift the asynchronous sensor through the synchroniser chain.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sensor};
    end
  end

  // Debounce: the level flips on the FILTER_LEN-th consecutive differing sample.
  always_ff @(posedge clock) begin
    if (reset) begin
      filt_cnt_q <= '0;
      level_q    <= 1'b0;
    end else if (sync_out == level_q) begin
      filt_cnt_q <= '0;
    end else if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
      filt_cnt_q <= '0;
      level_q    <= sync_out;
    end else begin
      filt_cnt_q <= filt_cnt_q + FW'(1);
    end
  end

  // Measurement completion / abort decisions and the would-be block sum.
  always_comb begin
    hit_d    = 1'b0;
    expire_d = 1'b0;
    sum_d    = acc_q + {4'b0000, count_q};
    if (state_q == MEASURE && enable) begin
      hit_d    = level_q;
      expire_d = !level_q && (count_q == TIMEOUT);
    end
  end

  // Measurement FSM with registered result and pulse outputs.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= IDLE;
      count_q       <= '0;
      lag_cycles_q  <= '0;
      lag_valid_q   <= 1'b0;
      lag_timeout_q <= 1'b0;
    end else begin
      lag_valid_q   <= hit_d;
      lag_timeout_q <= expire_d;
      if (!enable) begin
        state_q <= IDLE;
      end else begin
        unique case (state_q)
          IDLE: begin
            if (flash_start && !level_q) begin
              state_q <= MEASURE;
              count_q <= '0;
            end
          end
          MEASURE: begin
            if (hit_d) begin
              lag_cycles_q <= count_q;
              state_q      <= HOLDOFF;
            end else if (expire_d) begin
              state_q <= HOLDOFF;
            end else begin
              count_q <= count_q + COUNT_WIDTH'(1);
            end
          end
          HOLDOFF: begin
            // Wait for dark so one flash cannot yield two results.
            if (!level_q) state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Statistics: updated on a valid result; a coincident clear drops the sample.
  always_ff @(posedge clock) begin
    if (reset) begin
      min_q       <= '1;
      max_q       <= '0;
      acc_q       <= '0;
      nsamp_q     <= '0;
      avg_q       <= '0;
      avg_valid_q <= 1'b0;
    end else begin
      avg_valid_q <= 1'b0;
      if (clear_stats) begin
        min_q   <= '1;
        max_q   <= '0;
        acc_q   <= '0;
        nsamp_q <= '0;
      end else if (hit_d) begin
        if (count_q < min_q) min_q <= count_q;
        if (count_q > max_q) max_q <= count_q;
        if (nsamp_q == 4'd15) begin
          avg_q       <= sum_d[AW-1:4];
          avg_valid_q <= 1'b1;
          acc_q       <= '0;
          nsamp_q     <= '0;
        end else begin
          acc_q   <= sum_d;
          nsamp_q <= nsamp_q + 4'd1;
        end
      end
    end
  end

  assign sensor_level = level_q;
  assign busy         = (state_q != IDLE);
  assign lag_cycles   = lag_cycles_q;
  assign lag_valid    = lag_valid_q;
  assign lag_timeout  = lag_timeout_q;
  assign lag_min      = min_q;
  assign lag_max      = max_q;
  assign lag_avg      = avg_q;
  assign avg_valid    = avg_valid_q;

endmodule

// File: tb/tb_lag_measure.sv
// Bench for lag_measure: directed scenarios with randomised delays/orderings,
// results predicted from the end-to-end rules (lag = raw delay + 18, block
// mean of 16, min/max since clear) and compared through one checking task.
module tb_lag_measure;
  localparam int CW = 24;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          sensor = 1'b0;
  logic          flash_start = 1'b0;
  logic          enable = 1'b1;
  logic          clear_stats = 1'b0;
  logic          sensor_level, busy, lag_valid, lag_timeout, avg_valid;
  logic [CW-1:0] lag_cycles, lag_min, lag_max, lag_avg;

  lag_measure #(
    .SYNC_STAGES(2), .FILTER_LEN(16), .COUNT_WIDTH(CW), .TIMEOUT(24'd1000)
  ) dut (
    .clock(clock), .reset(reset), .sensor(sensor), .flash_start(flash_start),
    .enable(enable), .clear_stats(clear_stats), .sensor_level(sensor_level),
    .busy(busy), .lag_cycles(lag_cycles), .lag_valid(lag_valid),
    .lag_timeout(lag_timeout), .lag_min(lag_min), .lag_max(lag_max),
    .lag_avg(lag_avg), .avg_valid(avg_valid)
  );

  always #5 clock = ~clock;

  // Edge index: after posedge k (and #1), cyc == k.
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  int n_valid = 0, n_to = 0, n_avgv = 0;
  int v_cyc = -1, to_cyc = -1;
  logic [CW-1:0] v_lag, v_min, v_max, v_avg;
  logic v_avgv;
  bit lvl_hi = 0;
  always @(negedge clock) begin
    if (lag_valid === 1'b1) begin
      n_valid++; v_cyc = cyc; v_lag = lag_cycles; v_min = lag_min;
      v_max = lag_max; v_avg = lag_avg; v_avgv = avg_valid;
    end
    if (lag_timeout === 1'b1) begin n_to++; to_cyc = cyc; end
    if (avg_valid === 1'b1) n_avgv++;
    if (sensor_level === 1'b1) lvl_hi = 1;
  end

  int n_cmp = 0, n_bad = 0;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference statistics model.
  int m_min, m_max, m_avg = 0, last_lag = 0;
  bit m_avgv;
  int blk[$];
  task automatic model_clear();
    m_min = (1 << CW) - 1; m_max = 0; blk.delete();
  endtask
  task automatic model_valid(input int x, input bit clr);
    int sum;
    m_avgv = 0; last_lag = x;
    if (clr) begin model_clear(); return; end
    if (x < m_min) m_min = x;
    if (x > m_max) m_max = x;
    blk.push_back(x);
    if (blk.size() == 16) begin
      sum = 0;
      foreach (blk[i]) sum += blk[i];
      m_avg = sum / 16; m_avgv = 1; blk.delete();
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin @(posedge clock); #1; end
  endtask
  task automatic wait_until(input int t);
    while (cyc < t) tick(1);
  endtask
  task automatic flash(output int t);
    flash_start = 1'b1; t = cyc + 1; tick(1); flash_start = 1'b0;
  endtask
  task automatic wait_valid(input int nv0, input int limit);
    while (n_valid == nv0 && cyc < limit) tick(1);
  endtask
  task automatic check_pulse(input string tag, input int t_exp, input int lag_exp, input bit clr);
    chk({tag, "_valid_cyc"}, v_cyc, t_exp);
    chk({tag, "_lag"}, v_lag, lag_exp);
    model_valid(lag_exp, clr);
    chk({tag, "_avg_pulse"}, v_avgv, m_avgv);
    chk({tag, "_min"}, v_min, m_min);
    chk({tag, "_max"}, v_max, m_max);
    chk({tag, "_avg"}, v_avg, m_avg);
  endtask
  task automatic release_idle(input string tag);
    int d0;
    sensor = 1'b0; d0 = cyc;
    while (busy !== 1'b0 && cyc < d0 + 80) tick(1);
    chk({tag, "_busy_fall"}, cyc, d0 + 19);
    tick(2);
  endtask

  // One ordinary measurement; raw sensor rises just after edge T+d.
  task automatic measure(input string tag, input int d, input bit clr);
    int t, nv0, na0;
    nv0 = n_valid; na0 = n_avgv;
    flash(t);
    wait_until(t + d); sensor = 1'b1;
    if (clr) begin
      wait_until(t + d + 18); clear_stats = 1'b1; tick(1); clear_stats = 1'b0;
    end
    wait_valid(nv0, t + d + 80);
    check_pulse(tag, t + d + 19, d + 18, clr);
    release_idle(tag);
    chk({tag, "_valid_count"}, n_valid - nv0, 1);
    chk({tag, "_avg_count"}, n_avgv - na0, m_avgv);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t, t2, nv0, nt0, d;
    int order[16];
    model_clear();

    // Reset state.
    tick(3);
    chk("rst_level", sensor_level, 0);
    chk("rst_busy", busy, 0);
    chk("rst_lag", lag_cycles, 0);
    chk("rst_valid", lag_valid, 0);
    chk("rst_timeout", lag_timeout, 0);
    chk("rst_min", lag_min, (1 << CW) - 1);
    chk("rst_max", lag_max, 0);
    chk("rst_avg", lag_avg, 0);
    chk("rst_avg_valid", avg_valid, 0);
    reset = 1'b0;
    tick(5);

    // Basic: raw delay 100 -> lag 118, pulse at T+119.
    measure("basic", 100, 0);
    chk("basic_min118", lag_min, 118);
    chk("basic_max118", lag_max, 118);

    // 15-cycle glitch ignored, 16-cycle pulse accepted.
    nv0 = n_valid; lvl_hi = 0;
    flash(t);
    wait_until(t + 20); sensor = 1'b1;
    wait_until(t + 35); sensor = 1'b0;
    wait_until(t + 60);
    chk("glitch_level", lvl_hi, 0);
    chk("glitch_novalid", n_valid - nv0, 0);
    chk("glitch_busy", busy, 1);
    sensor = 1'b1;
    wait_until(t + 76); sensor = 1'b0;
    wait_valid(nv0, t + 140);
    check_pulse("pulse16", t + 79, 78, 0);
    while (busy !== 1'b0 && cyc < t + 200) tick(1);
    chk("pulse16_idle", cyc, t + 95);
    chk("pulse16_count", n_valid - nv0, 1);
    tick(3);

    // Timeout with the sensor held dark.
    nv0 = n_valid; nt0 = n_to;
    flash(t);
    while (n_to == nt0 && cyc < t + 1100) tick(1);
    chk("to_cyc", to_cyc, t + 1001);
    chk("to_lag_held", lag_cycles, last_lag);
    chk("to_min_held", lag_min, m_min);
    chk("to_max_held", lag_max, m_max);
    tick(3);
    chk("to_idle", busy, 0);
    chk("to_novalid", n_valid - nv0, 0);
    chk("to_one_pulse", n_to - nt0, 1);

    // Flash while already lit is ignored.
    sensor = 1'b1; tick(25);
    chk("lit_level", sensor_level, 1);
    nv0 = n_valid;
    flash(t); tick(5);
    chk("lit_busy", busy, 0);
    sensor = 1'b0; tick(25);
    chk("lit_dark", sensor_level, 0);
    chk("lit_novalid", n_valid - nv0, 0);

    // Second flash during MEASURE ignored.
    nv0 = n_valid;
    flash(t);
    wait_until(t + 10); flash(t2);
    chk("dbl_busy", busy, 1);
    wait_until(t + 50); sensor = 1'b1;
    wait_valid(nv0, t + 140);
    check_pulse("dbl", t + 69, 68, 0);
    release_idle("dbl");
    chk("dbl_count", n_valid - nv0, 1);

    // Enable dropped mid-measure: discarded without pulses.
    nv0 = n_valid; nt0 = n_to;
    flash(t);
    wait_until(t + 20);
    chk("en_busy", busy, 1);
    enable = 1'b0; tick(1);
    chk("en_abort_idle", busy, 0);
    sensor = 1'b1;
    wait_until(t + 30); enable = 1'b1;
    wait_until(t + 90);
    chk("en_novalid", n_valid - nv0, 0);
    chk("en_noto", n_to - nt0, 0);
    chk("en_idle", busy, 0);
    sensor = 1'b0; tick(25);

    // Clear, then a block of 16 with delays 100..115 in random order.
    clear_stats = 1'b1; tick(1); clear_stats = 1'b0;
    model_clear();
    chk("clr_min", lag_min, (1 << CW) - 1);
    chk("clr_max", lag_max, 0);
    chk("clr_avg_held", lag_avg, m_avg);
    chk("clr_lag_held", lag_cycles, last_lag);
    for (int i = 0; i < 16; i++) order[i] = 100 + i;
    for (int i = 15; i > 0; i--) begin
      int j, tmp;
      j = $urandom_range(i, 0);
      tmp = order[i]; order[i] = order[j]; order[j] = tmp;
    end
    for (int i = 0; i < 16; i++) measure("blk", order[i], 0);
    chk("blk_avg125", v_avg, 125);
    chk("blk_avgv", v_avgv, 1);
    chk("blk_min118", v_min, 118);
    chk("blk_max133", v_max, 133);

    // Random delays.
    for (int i = 0; i < 6; i++) begin
      d = $urandom_range(300, 1);
      measure("rnd", d, 0);
    end

    // Clear coincident with a valid result: clear wins, lag still updates.
    d = $urandom_range(200, 20);
    measure("coclr", d, 1);
    chk("coclr_min", lag_min, (1 << CW) - 1);
    chk("coclr_max", lag_max, 0);
    chk("coclr_lag", lag_cycles, d + 18);

    // First sample after that clear sets both min and max.
    measure("post", 40, 0);
    chk("post_min58", lag_min, 58);
    chk("post_max58", lag_max, 58);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
